// File: rtl/mem_responder.sv
// mem_responder
//   Multi-cycle data-memory responder sitting at the target end of the memory
//   stage request interface. One word read or write is accepted at a time.
//   The initiator is held off with `stall` while the access is in flight.
//   A single `done` pulse marks completion, and it carries read data for loads.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   addr       byte address; word index is addr[ADDR_BITS:1]
//   writeData  store data
//   memRead    read request
//   memWrite   write request
//   halt       processor halted; no new requests are accepted
//   readData   load data, meaningful only while done=1
//   stall      busy, initiator must hold its pipeline
//   done       one-cycle completion pulse
//   err        one-cycle error pulse (conflicting or unaligned request)
module mem_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        halt,
  output logic [15:0] readData,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int CNT_W  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT                state, nextState;
  logic [CNT_W-1:0]     count, nextCount;
  logic [DATA_W-1:0]    mem [DEPTH];

  logic [ADDR_BITS-1:0] inIdx, latIdx, commitIdx;
  logic [DATA_W-1:0]    latData, commitData;
  logic                 latWrite, commitWrite;
  logic                 accepting, anyReq, badReq, accept, errNext, enterResp;
  logic                 unusedAddrBits;

  // Upper address bits are deliberately ignored.
  assign unusedAddrBits = ^addr[15:ADDR_BITS+1];

  assign inIdx     = addr[ADDR_BITS:1];
  assign accepting = (state != WAIT) && !halt;
  assign anyReq    = memRead | memWrite;
  assign badReq    = (memRead & memWrite) | (anyReq & addr[0]);
  assign accept    = accepting && (memRead ^ memWrite) && !addr[0];
  assign errNext   = accepting && badReq;

  always_comb begin
    nextState = state;
    nextCount = count;
    case (state)
      WAIT: begin
        nextCount = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          nextState = RESP;
        end
      end
      default: begin
        // IDLE and RESP both accept; RESP falls back to IDLE when nothing new arrives.
        nextState = IDLE;
        if (accept) begin
          if (LATENCY > 1) begin
            nextState = WAIT;
            nextCount = CNT_W'(LATENCY - 1);
          end else begin
            nextState = RESP;
            nextCount = '0;
          end
        end
      end
    endcase
  end

  // Entering RESP from WAIT uses the latched request; with LATENCY=1 the
  // request goes straight to RESP, so the live inputs are used instead.
  assign enterResp   = (nextState == RESP);
  assign commitIdx   = (state == WAIT) ? latIdx   : inIdx;
  assign commitData  = (state == WAIT) ? latData  : writeData;
  assign commitWrite = (state == WAIT) ? latWrite : memWrite;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      err      <= 1'b0;
      readData <= '0;
    end else begin
      state <= nextState;
      count <= nextCount;
      err   <= errNext;
      if (enterResp) begin
        // A write echoes the stored value back on readData.
        readData <= commitWrite ? commitData : mem[commitIdx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      latIdx   <= inIdx;
      latData  <= writeData;
      latWrite <= memWrite;
    end
  end

  // Storage is never cleared; a write held in reset is dropped.
  always_ff @(posedge clk) begin
    if (enterResp && commitWrite && !rst) begin
      mem[commitIdx] <= commitData;
    end
  end

  assign stall = (state == WAIT);
  assign done  = (state == RESP);

endmodule
